// File: rtl/ga_loader_pkg.sv
// Shared types and LFSR tap table for the GA initial-population loader.
package ga_loader_pkg;

  typedef enum logic [1:0] {
    MODE_EXT     = 2'b00,
    MODE_LFSR    = 2'b01,
    MODE_SEED    = 2'b10,
    MODE_ILLEGAL = 2'b11
  } load_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  // Right-shifting Galois toggle masks giving maximal-length sequences.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       lfsr_taps = 32'h0000_00B8;
      9:       lfsr_taps = 32'h0000_0110;
      10:      lfsr_taps = 32'h0000_0240;
      11:      lfsr_taps = 32'h0000_0500;
      12:      lfsr_taps = 32'h0000_0E08;
      13:      lfsr_taps = 32'h0000_1C80;
      14:      lfsr_taps = 32'h0000_3802;
      15:      lfsr_taps = 32'h0000_6000;
      16:      lfsr_taps = 32'h0000_B400;
      17:      lfsr_taps = 32'h0001_2000;
      18:      lfsr_taps = 32'h0002_0400;
      19:      lfsr_taps = 32'h0007_2000;
      20:      lfsr_taps = 32'h0009_0000;
      21:      lfsr_taps = 32'h0014_0000;
      22:      lfsr_taps = 32'h0030_0000;
      23:      lfsr_taps = 32'h0042_0000;
      24:      lfsr_taps = 32'h00E1_0000;
      25:      lfsr_taps = 32'h0120_0000;
      26:      lfsr_taps = 32'h0200_0023;
      27:      lfsr_taps = 32'h0400_0013;
      28:      lfsr_taps = 32'h0900_0000;
      29:      lfsr_taps = 32'h1400_0000;
      30:      lfsr_taps = 32'h2000_0029;
      31:      lfsr_taps = 32'h4800_0000;
      32:      lfsr_taps = 32'h8020_0003;
      default: lfsr_taps = 32'h0000_00B8;
    endcase
  endfunction

endpackage

// File: rtl/ga_loader_lfsr.sv
// Galois LFSR that steps only when its value is consumed.
module ga_loader_lfsr #(
  parameter int                 WIDTH = 16,
  parameter logic [WIDTH-1:0]   SEED  = WIDTH'(16'hACE1),
  parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(16'hB400)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [WIDTH-1:0] value
);

  // Shift right; when the bit falling out is 1, fold the tap mask back in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= SEED;
    end else if (advance) begin
      value <= value[0] ? ((value >> 1) ^ TAPS) : (value >> 1);
    end
  end

endmodule

// File: rtl/ga_pop_loader.sv
// Initial-population loader: external stream, LFSR fill or seed-table pick,
// written one chromosome at a time through an acknowledged write port.
module ga_pop_loader
  import ga_loader_pkg::*;
#(
  parameter int          CHROMOSOME_WIDTH = 16,
  parameter int          POPULATION_MAX   = 100,
  parameter int          ADDR_WIDTH       = $clog2(POPULATION_MAX),
  parameter int          SEED_DEPTH       = 8,
  parameter logic [31:0] LFSR_SEED        = 32'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [1:0]                    mode,
  input  logic [ADDR_WIDTH:0]           population_size,
  input  logic                          seed_wr_en,
  input  logic [$clog2(SEED_DEPTH)-1:0] seed_wr_addr,
  input  logic [CHROMOSOME_WIDTH-1:0]   seed_wr_data,
  input  logic                          in_valid,
  input  logic [CHROMOSOME_WIDTH-1:0]   in_data,
  output logic                          in_ready,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [CHROMOSOME_WIDTH-1:0]   wr_data,
  input  logic                          wr_ack,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic                          aborted,
  output logic [ADDR_WIDTH:0]           loaded_count
);

  localparam int SEED_AW = $clog2(SEED_DEPTH);
  localparam logic [31:0] TAPS_32 = lfsr_taps(CHROMOSOME_WIDTH);
  localparam logic [CHROMOSOME_WIDTH-1:0] TAPS = TAPS_32[CHROMOSOME_WIDTH-1:0];
  localparam logic [CHROMOSOME_WIDTH-1:0] SEED = LFSR_SEED[CHROMOSOME_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0] SIZE_MAX = (ADDR_WIDTH+1)'(POPULATION_MAX);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FETCH = ST_FETCH;
  localparam logic [1:0] S_WRITE = ST_WRITE;
  localparam logic [1:0] S_DONE  = ST_DONE;

  logic [1:0]                  state;
  load_mode_t                  mode_q;
  logic [ADDR_WIDTH:0]         size_q;
  logic [CHROMOSOME_WIDTH-1:0] data_q;
  logic [CHROMOSOME_WIDTH-1:0] seed_table [SEED_DEPTH];
  logic [CHROMOSOME_WIDTH-1:0] lfsr_value;
  logic [ADDR_WIDTH:0]         next_count;
  logic                        advance;
  logic                        bad_start;

  // The random sources consume the LFSR once per fetch; abort cancels the fetch.
  assign advance    = (state == S_FETCH) && !abort &&
                      ((mode_q == MODE_LFSR) || (mode_q == MODE_SEED));
  assign bad_start  = (population_size == '0) || (population_size > SIZE_MAX) ||
                      (mode == MODE_ILLEGAL);
  assign next_count = loaded_count + 1'b1;

  // Abort gates in_ready so a beat is never handshaken on the cycle it is dropped.
  assign in_ready = (state == S_FETCH) && (mode_q == MODE_EXT) && !abort;
  assign wr_en    = (state == S_WRITE);
  assign wr_addr  = loaded_count[ADDR_WIDTH-1:0];
  assign wr_data  = data_q;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

  ga_loader_lfsr #(
    .WIDTH (CHROMOSOME_WIDTH),
    .SEED  (SEED),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .value   (lfsr_value)
  );

  // Seed table is programmable only while idle so a load sees a frozen table.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SEED_DEPTH; i++) seed_table[i] <= '0;
    end else if ((state == S_IDLE) && seed_wr_en) begin
      seed_table[seed_wr_addr] <= seed_wr_data;
    end
  end

  // Load sequencer; abort overrides everything, including a same-cycle wr_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      mode_q       <= MODE_EXT;
      size_q       <= '0;
      data_q       <= '0;
      loaded_count <= '0;
      error        <= 1'b0;
      aborted      <= 1'b0;
    end else begin
      error   <= 1'b0;
      aborted <= 1'b0;
      if ((state != S_IDLE) && abort) begin
        state   <= S_IDLE;
        aborted <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              mode_q       <= load_mode_t'(mode);
              size_q       <= population_size;
              loaded_count <= '0;
              if (bad_start) error <= 1'b1;
              else           state <= S_FETCH;
            end
          end
          S_FETCH: begin
            case (mode_q)
              MODE_EXT: begin
                if (in_valid) begin
                  data_q <= in_data;
                  state  <= S_WRITE;
                end
              end
              MODE_LFSR: begin
                data_q <= lfsr_value;
                state  <= S_WRITE;
              end
              MODE_SEED: begin
                data_q <= seed_table[lfsr_value[SEED_AW-1:0]];
                state  <= S_WRITE;
              end
              default: state <= S_IDLE;
            endcase
          end
          S_WRITE: begin
            if (wr_ack) begin
              loaded_count <= next_count;
              state        <= (next_count == size_q) ? S_DONE : S_FETCH;
            end
          end
          S_DONE: state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/ga_pop_loader.md
Name: ga_pop_loader

Overview:
- Parametrised initial-population loader that sits between an external host and the GA population memory in ga_top.
- Replaces the ad-hoc load_data_now single-edge handshake with a valid/ready input stream and an acknowledged memory write port.
- Adds two self-seeding modes: LFSR random fill and random pick from a programmable seed table.
- Asserts done once population_size chromosomes have been written.

Parameters:
- CHROMOSOME_WIDTH, 16, chromosome bit width; legal range 8..32.
- POPULATION_MAX, 100, maximum population depth.
- ADDR_WIDTH, $clog2(POPULATION_MAX), address width of the population memory.
- SEED_DEPTH, 8, seed-table entries; power of two, >=2.
- LFSR_SEED, 'hACE1, LFSR reset value; must be non-zero (truncated to CHROMOSOME_WIDTH).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin load; sampled only in IDLE
- abort  in  1  cancel load from any state
- mode  in  2  00 external stream, 01 LFSR fill, 10 seed-table pick, 11 illegal
- population_size  in  ADDR_WIDTH+1  number of chromosomes to load
- seed_wr_en  in  1  seed-table write strobe; honoured only in IDLE
- seed_wr_addr  in  $clog2(SEED_DEPTH)  seed-table write address
- seed_wr_data  in  CHROMOSOME_WIDTH  seed-table write data
- in_valid  in  1  external chromosome valid
- in_data  in  CHROMOSOME_WIDTH  external chromosome
- in_ready  out  1  loader accepts in_data
- wr_en  out  1  population memory write request
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  CHROMOSOME_WIDTH  write data
- wr_ack  in  1  memory accepted write
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on successful completion
- error  out  1  one-cycle pulse on rejected start
- aborted  out  1  one-cycle pulse on abort acknowledge
- loaded_count  out  ADDR_WIDTH+1  chromosomes written this load

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; loaded_count 0; LFSR = LFSR_SEED; seed table cleared to 0.
- State machine: IDLE, FETCH, WRITE, DONE.
- IDLE, start=1:
  - Latch mode and population_size; clear loaded_count.
  - If population_size==0, population_size>POPULATION_MAX, or mode==11: error pulses next cycle, no writes, stay IDLE.
  - Otherwise go to FETCH.
- FETCH, mode 00: in_ready=1; the transfer occurs in the cycle in_valid&&in_ready; capture in_data, go to WRITE. in_ready=0 in every other state.
- FETCH, mode 01: capture current LFSR value, advance LFSR one step, go to WRITE (1 cycle).
- FETCH, mode 10: capture seed_table[lfsr[$clog2(SEED_DEPTH)-1:0]], advance LFSR, go to WRITE.
- WRITE:
  - wr_en=1, wr_addr=loaded_count[ADDR_WIDTH-1:0], wr_data=captured value.
  - wr_en, wr_addr and wr_data are held stable until wr_ack=1. wr_ack is ignored when wr_en=0.
  - On wr_ack: loaded_count++. If the new count equals population_size go to DONE, else go to FETCH.
- DONE: done=1 for one cycle; next state IDLE. loaded_count holds its value until the next accepted start.
- LFSR: Galois, width CHROMOSOME_WIDTH, maximal-length taps taken from the package. It advances only on consumption in modes 01/10 and is never reset between loads, so successive loads differ. Zero state is unreachable.
- Throughput: with wr_ack tied high, modes 01/10 write one chromosome every 2 cycles. Mode 00 latency is 2 cycles from transfer to wr_en fall.
- abort=1 in any non-IDLE state:
  - Go to IDLE next cycle and pulse aborted.
  - done is not asserted.
  - An in-flight write is dropped (wr_en falls); loaded_count retains the completed count.
  - abort in IDLE has no effect.
- Simultaneous events:
  - abort beats wr_ack; the write is not counted.
  - start while busy is ignored.
  - seed_wr_en while busy is ignored.
- Asynchronous reset mid-load: immediate return to reset values; no partial-load status is retained.

Decomposition:
- Package ga_loader_pkg holds:
  - enum load_mode_t (MODE_EXT, MODE_LFSR, MODE_SEED, MODE_ILLEGAL);
  - enum loader_state_t;
  - function lfsr_taps(width) returning the tap mask for widths 8..32.
- One sub-module, ga_loader_lfsr: parametrised width, seed and taps; ports clk, rst, advance, value.

Test Plan:
- Mode 00, size 4, in_valid always 1, in_data 0x0300/0x0101/0x0010/0x2001, wr_ack tied 1 -> writes addr 0..3 with those values in order, done at cycle ~9, loaded_count=4.
- Mode 00, in_valid toggling, wr_ack delayed 3 cycles per write -> wr_en/wr_addr/wr_data stable while waiting, no data lost, no duplicate addresses.
- Mode 01, size 10, LFSR_SEED 0xACE1 -> 10 writes matching a reference LFSR model, all non-zero. A second load continues the sequence without repeating.
- Mode 10, table {0x0300,0x0101,0x0010,0x2001,0x0003,0x3004,0x0000,0xFFFF}, size 100 -> every wr_data is a table member, done after 100 writes.
- Start with size 0, size 101, or mode 11 -> error pulse only, busy stays 0, no wr_en.
- Abort asserted in the same cycle as the 3rd wr_ack -> aborted pulse, loaded_count=2, no done. A subsequent start loads normally. Asserting rst=0 mid-load returns all outputs to 0 immediately.
